div_operand_sequencer: RTL and testbench

DIV_OPERAND_SEQUENCER -- requirements
Module: div_operand_sequencer

---
 rtl/div_operand_sequencer.sv | 113 +++++++++++
 tb/tb_div_operand_sequencer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/div_operand_sequencer.sv
// Feeds dividend then divisor over one shared bus to a repeated-subtraction divider,
// waits for its quotient (with abort on timeout) and holds the result until consumed.
module div_operand_sequencer #(
  parameter int WIDTH    = 16,
  parameter int LOAD_CYC = 2,
  parameter int TIMEOUT  = 65600
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_dividend,
  input  logic [WIDTH-1:0] req_divisor,
  output logic             div_start,
  output logic [WIDTH-1:0] div_data,
  input  logic             div_done,
  input  logic [WIDTH-1:0] div_quotient,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_quotient,
  output logic             rsp_dbz,
  output logic             rsp_timeout,
  output logic             busy
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam int LD_W  = (LOAD_CYC > 1) ? $clog2(LOAD_CYC) : 1;

  typedef enum logic [1:0] {IDLE, FEED_A, WAIT_Q, RESP} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [LD_W-1:0]  ld_cnt;
  logic [WIDTH-1:0] divisor_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

  // Operand capture is pure data; the dividend lives in div_data while it is fed.
  always_ff @(posedge clock) begin
    if (state == IDLE && req_valid) divisor_q <= req_divisor;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      cnt          <= '0;
      ld_cnt       <= '0;
      div_start    <= 1'b0;
      div_data     <= '0;
      rsp_quotient <= '0;
      rsp_dbz      <= 1'b0;
      rsp_timeout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (req_divisor == '0) begin
              state        <= RESP;
              rsp_quotient <= '0;
              rsp_dbz      <= 1'b1;
              rsp_timeout  <= 1'b0;
            end else begin
              state     <= FEED_A;
              div_start <= 1'b1;
              div_data  <= req_dividend;
              ld_cnt    <= '0;
            end
          end
        end
        FEED_A: begin
          if (ld_cnt == LD_W'(LOAD_CYC - 1)) begin
            state    <= WAIT_Q;
            div_data <= divisor_q;
            cnt      <= '0;
          end else begin
            ld_cnt <= ld_cnt + LD_W'(1);
          end
        end
        WAIT_Q: begin
          // A done arriving on the timeout edge still delivers its quotient.
          if (div_done) begin
            state        <= RESP;
            rsp_quotient <= div_quotient;
            rsp_dbz      <= 1'b0;
            rsp_timeout  <= 1'b0;
            div_start    <= 1'b0;
            div_data     <= '0;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            state        <= RESP;
            rsp_quotient <= '0;
            rsp_dbz      <= 1'b0;
            rsp_timeout  <= 1'b1;
            div_start    <= 1'b0;
            div_data     <= '0;
          end else begin
            cnt <= sat_inc(cnt);
          end
        end
        RESP: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_operand_sequencer.sv
// Directed bench for div_operand_sequencer with a small behavioural divider that
// answers a fixed number of cycles after the divisor appears.
module tb_div_operand_sequencer;
  localparam int WIDTH    = 16;
  localparam int LOAD_CYC = 2;
  localparam int TIMEOUT  = 20;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [WIDTH-1:0] req_dividend = '0;
  logic [WIDTH-1:0] req_divisor = '0;
  logic             div_start;
  logic [WIDTH-1:0] div_data;
  logic             div_done = 1'b0;
  logic [WIDTH-1:0] div_quotient = 16'hBEEF;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [WIDTH-1:0] rsp_quotient;
  logic             rsp_dbz;
  logic             rsp_timeout;
  logic             busy;

  int total = 0;
  int bad = 0;

  div_operand_sequencer #(.WIDTH(WIDTH), .LOAD_CYC(LOAD_CYC), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dividend(req_dividend), .req_divisor(req_divisor),
    .div_start(div_start), .div_data(div_data),
    .div_done(div_done), .div_quotient(div_quotient),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_quotient(rsp_quotient), .rsp_dbz(rsp_dbz), .rsp_timeout(rsp_timeout),
    .busy(busy)
  );

  always #5 clock = ~clock;

  // Divider model: first start cycle carries the dividend, cycle LOAD_CYC the divisor;
  // done pulses with the true quotient at start-cycle LOAD_CYC+2, else the bus shows BEEF.
  int               ph = 0;
  logic [WIDTH-1:0] ma = '0, mb = 16'd1;
  bit               model_en = 1'b1;
  always @(posedge clock) begin
    if (!div_start) begin
      ph <= 0; div_done <= 1'b0; div_quotient <= 16'hBEEF;
    end else begin
      if (ph == 0) ma <= div_data;
      if (ph == LOAD_CYC) mb <= div_data;
      ph <= ph + 1;
      if (model_en && ph == LOAD_CYC + 2 && mb != 0) begin
        div_done <= 1'b1; div_quotient <= ma / mb;
      end else begin
        div_done <= 1'b0; div_quotient <= 16'hBEEF;
      end
    end
  end

  // Offers one request from IDLE and waits (bounded) for rsp_valid; lat counts negedges from accept.
  task automatic send_and_wait(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               output int lat, output int n_a, output int n_b,
                               output int n_s, output bit got);
    lat = 0; n_a = 0; n_b = 0; n_s = 0; got = 1'b0;
    @(negedge clock); req_dividend = a; req_divisor = b; req_valid = 1'b1;
    @(negedge clock); req_valid = 1'b0;
    for (int i = 1; i <= 200; i++) begin
      if (rsp_valid) begin lat = i; got = 1'b1; break; end
      if (div_start) n_s++;
      if (div_start && div_data == a) n_a++;
      else if (div_start && div_data == b) n_b++;
      @(negedge clock);
    end
  endtask

  task automatic release_rsp();
    rsp_ready = 1'b1;
    @(negedge clock);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    total++;
    if ({req_ready, busy, div_start, rsp_valid, rsp_dbz, rsp_timeout} !== 6'b100000 ||
        div_data !== 16'd0 || rsp_quotient !== 16'd0) begin
      bad++;
      $display("FAIL reset_state: ready=%b busy=%b start=%b data=%0d valid=%b q=%0d dbz=%b to=%b, need ready=1 rest 0",
               req_ready, busy, div_start, div_data, rsp_valid, rsp_quotient, rsp_dbz, rsp_timeout);
    end
    @(negedge clock); reset_n = 1'b1;
    @(negedge clock);
    total++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL post_reset_idle: ready=%b busy=%b need 1/0", req_ready, busy);
    end
  endtask

  task automatic test_basic();
    int lat, n_a, n_b, n_s; bit got;
    send_and_wait(16'd28, 16'd4, lat, n_a, n_b, n_s, got);
    total++; if (!got) begin bad++; $display("FAIL basic_rsp: no rsp_valid within bound"); end
    total++; if (n_a !== 2) begin bad++; $display("FAIL basic_feed: dividend cycles=%0d need 2", n_a); end
    total++; if (n_b !== 4) begin bad++; $display("FAIL basic_wait: divisor cycles=%0d need 4", n_b); end
    total++; if (lat !== 7) begin bad++; $display("FAIL basic_latency: got %0d need 7", lat); end
    total++;
    if (rsp_quotient !== 16'd7 || rsp_dbz !== 1'b0 || rsp_timeout !== 1'b0) begin
      bad++; $display("FAIL basic_result: q=%0d dbz=%b to=%b need 7/0/0", rsp_quotient, rsp_dbz, rsp_timeout);
    end
    total++;
    if (div_start !== 1'b0 || div_data !== 16'd0 || busy !== 1'b1 || req_ready !== 1'b0) begin
      bad++; $display("FAIL basic_resp_bus: start=%b data=%0d busy=%b ready=%b need 0/0/1/0",
                      div_start, div_data, busy, req_ready);
    end
    release_rsp();
    total++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      bad++; $display("FAIL basic_idle_after: ready=%b valid=%b need 1/0", req_ready, rsp_valid);
    end
  endtask

  task automatic test_dbz();
    int lat, n_a, n_b, n_s; bit got;
    send_and_wait(16'd5, 16'd0, lat, n_a, n_b, n_s, got);
    total++; if (!got || lat !== 1) begin bad++; $display("FAIL dbz_latency: got=%b lat=%0d need lat 1", got, lat); end
    total++;
    if (rsp_quotient !== 16'd0 || rsp_dbz !== 1'b1 || rsp_timeout !== 1'b0 || div_start !== 1'b0) begin
      bad++; $display("FAIL dbz_result: q=%0d dbz=%b to=%b start=%b need 0/1/0/0",
                      rsp_quotient, rsp_dbz, rsp_timeout, div_start);
    end
    release_rsp();
    total++; if (n_s !== 0 || div_start !== 1'b0) begin bad++; $display("FAIL dbz_no_start: start cycles=%0d need 0", n_s); end
  endtask

  task automatic test_hold();
    int lat, n_a, n_b, n_s; bit got;
    send_and_wait(16'd3, 16'd9, lat, n_a, n_b, n_s, got);
    total++; if (!got) begin bad++; $display("FAIL hold_rsp: no rsp_valid within bound"); end
    for (int i = 0; i < 10; i++) begin
      total++;
      if (rsp_valid !== 1'b1 || rsp_quotient !== 16'd0 || req_ready !== 1'b0 ||
          rsp_dbz !== 1'b0 || rsp_timeout !== 1'b0) begin
        bad++; $display("FAIL hold_stable[%0d]: valid=%b q=%0d ready=%b dbz=%b to=%b need 1/0/0/0/0",
                        i, rsp_valid, rsp_quotient, req_ready, rsp_dbz, rsp_timeout);
      end
      @(negedge clock);
    end
    release_rsp();
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL hold_release: ready=%b need 1", req_ready); end
  endtask

  task automatic test_timeout();
    int lat, n_a, n_b, n_s; bit got;
    model_en = 1'b0;
    send_and_wait(16'd50, 16'd7, lat, n_a, n_b, n_s, got);
    total++; if (!got) begin bad++; $display("FAIL timeout_rsp: no rsp_valid within bound"); end
    total++; if (n_b !== TIMEOUT) begin bad++; $display("FAIL timeout_wait: wait cycles=%0d need %0d", n_b, TIMEOUT); end
    total++; if (lat !== 23) begin bad++; $display("FAIL timeout_latency: got %0d need 23", lat); end
    total++;
    if (rsp_timeout !== 1'b1 || rsp_quotient !== 16'd0 || rsp_dbz !== 1'b0) begin
      bad++; $display("FAIL timeout_result: to=%b q=%0d dbz=%b need 1/0/0", rsp_timeout, rsp_quotient, rsp_dbz);
    end
    release_rsp();
    model_en = 1'b1;
  endtask

  task automatic test_reset_mid_job();
    int lat, n_a, n_b, n_s, seen; bit got, in_wait;
    in_wait = 1'b0; seen = 0;
    @(negedge clock); req_dividend = 16'd100; req_divisor = 16'd3; req_valid = 1'b1;
    @(negedge clock); req_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (div_start && div_data == 16'd3) begin in_wait = 1'b1; break; end
      @(negedge clock);
    end
    total++; if (!in_wait) begin bad++; $display("FAIL midreset_reach_wait: divisor never presented"); end
    reset_n = 1'b0;
    #1;
    total++;
    if ({req_ready, busy, div_start, rsp_valid, rsp_dbz, rsp_timeout} !== 6'b100000 ||
        div_data !== 16'd0 || rsp_quotient !== 16'd0) begin
      bad++; $display("FAIL midreset_async: ready=%b busy=%b start=%b data=%0d valid=%b q=%0d need ready=1 rest 0",
                      req_ready, busy, div_start, div_data, rsp_valid, rsp_quotient);
    end
    @(negedge clock); @(negedge clock); reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (rsp_valid || div_start || !req_ready) seen++;
      @(negedge clock);
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL midreset_abandon: non-idle cycles=%0d need 0", seen); end
    send_and_wait(16'd100, 16'd5, lat, n_a, n_b, n_s, got);
    total++;
    if (!got || rsp_quotient !== 16'd20 || rsp_dbz !== 1'b0 || rsp_timeout !== 1'b0) begin
      bad++; $display("FAIL midreset_next_job: got=%b q=%0d dbz=%b to=%b need 20/0/0", got, rsp_quotient, rsp_dbz, rsp_timeout);
    end
    release_rsp();
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] resp [2];
    int acc, nresp, gap;
    bit pend, pendr;
    logic [WIDTH-1:0] qpre;
    acc = 0; nresp = 0; gap = 0;
    resp[0] = '0; resp[1] = '0;
    rsp_ready = 1'b1;
    @(negedge clock); req_dividend = 16'd28; req_divisor = 16'd4; req_valid = 1'b1;
    for (int cyc = 0; cyc < 200 && nresp < 2; cyc++) begin
      pend = req_ready && req_valid;
      pendr = rsp_valid && rsp_ready;
      qpre = rsp_quotient;
      @(negedge clock);
      if (pend) begin
        acc++;
        if (acc == 1) begin req_dividend = 16'd9; req_divisor = 16'd3; end
        else req_valid = 1'b0;
      end
      if (pendr) begin resp[nresp] = qpre; nresp++; end
      if (nresp == 1 && acc == 1 && !div_start) gap++;
    end
    req_valid = 1'b0; rsp_ready = 1'b0;
    total++; if (nresp !== 2) begin bad++; $display("FAIL b2b_count: responses=%0d need 2", nresp); end
    total++; if (resp[0] !== 16'd7) begin bad++; $display("FAIL b2b_first: q=%0d need 7", resp[0]); end
    total++; if (resp[1] !== 16'd3) begin bad++; $display("FAIL b2b_second: q=%0d need 3", resp[1]); end
    total++; if (gap < 1) begin bad++; $display("FAIL b2b_gap: start-low cycles between jobs=%0d need >=1", gap); end
    @(negedge clock);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_dbz();
    test_hold();
    test_timeout();
    test_reset_mid_job();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time bound");
    $fatal(1, "watchdog");
  end
endmodule
